// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared constants, state type and limit helpers for dsp_mac_pipe
package dsp_mac_pkg;

  localparam int OP_WIDTH    = 4;
  localparam int OP_PRE_EN   = 0;
  localparam int OP_PRE_SUB  = 1;
  localparam int OP_POST_SUB = 2;
  localparam int OP_LOAD_C   = 3;

  // Limits are built in a wide vector and sliced down to the user width.
  localparam int LIM_WIDTH = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // Largest signed value representable in `width` bits (0111...1).
  function automatic logic [LIM_WIDTH-1:0] signed_max(input int width);
    logic [LIM_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LIM_WIDTH; i++) begin
      if (i < width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest signed value representable in `width` bits (1000...0).
  function automatic logic [LIM_WIDTH-1:0] signed_min(input int width);
    logic [LIM_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LIM_WIDTH; i++) begin
      if (i == width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_mac_acc.sv
// rtl/dsp_mac_acc.sv - group accumulator stage with saturation, sticky overflow and beat count
module dsp_mac_acc
  import dsp_mac_pkg::*;
#(
  parameter int M_WIDTH   = 37,
  parameter int P_WIDTH   = 48,
  parameter int CNT_WIDTH = 8,
  parameter int SATURATE  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        adv_i,
  input  logic                        valid_i,
  input  logic signed [M_WIDTH-1:0]   m_i,
  input  logic signed [P_WIDTH-1:0]   c_i,
  input  logic                        post_sub_i,
  input  logic                        load_c_i,
  input  logic                        last_i,
  input  logic                        out_ready_i,
  output logic                        out_valid_o,
  output logic signed [P_WIDTH-1:0]   p_o,
  output logic                        ovf_o,
  output logic [CNT_WIDTH-1:0]        cnt_o
);

  localparam logic [LIM_WIDTH-1:0] P_MAX_W = signed_max(P_WIDTH);
  localparam logic [LIM_WIDTH-1:0] P_MIN_W = signed_min(P_WIDTH);
  localparam logic signed [P_WIDTH-1:0] P_MAX = P_MAX_W[P_WIDTH-1:0];
  localparam logic signed [P_WIDTH-1:0] P_MIN = P_MIN_W[P_WIDTH-1:0];

  acc_state_e                 state_q, state_d;
  logic signed [P_WIDTH-1:0]  acc_q, acc_d;
  logic                       ovf_acc_q, ovf_acc_d;
  logic [CNT_WIDTH-1:0]       cnt_acc_q, cnt_acc_d;
  logic signed [P_WIDTH-1:0]  p_q, p_d;
  logic                       ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       out_valid_q, out_valid_d;

  logic signed [P_WIDTH-1:0]  base;
  logic signed [P_WIDTH:0]    base_ext;
  logic signed [P_WIDTH:0]    m_ext;
  logic signed [P_WIDTH:0]    sum;
  logic                       overflow;
  logic signed [P_WIDTH-1:0]  result;
  logic                       grp_ovf;
  logic [CNT_WIDTH-1:0]       cnt_inc;

  // Beat arithmetic: pick the base, add/sub the product one bit wider, then clamp or wrap.
  always_comb begin
    base = acc_q;
    if (state_q == IDLE) base = load_c_i ? c_i : '0;
    base_ext = {base[P_WIDTH-1], base};
    m_ext    = {{(P_WIDTH + 1 - M_WIDTH){m_i[M_WIDTH-1]}}, m_i};
    sum      = post_sub_i ? (base_ext - m_ext) : (base_ext + m_ext);
    overflow = sum[P_WIDTH] ^ sum[P_WIDTH-1];
    result   = sum[P_WIDTH-1:0];
    if (overflow && (SATURATE != 0)) result = sum[P_WIDTH] ? P_MIN : P_MAX;
    grp_ovf  = ovf_acc_q | overflow;
    cnt_inc  = (&cnt_acc_q) ? cnt_acc_q : cnt_acc_q + CNT_WIDTH'(1);
  end

  // FSM and register next-state; nothing moves while the pipeline is stalled.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    cnt_acc_d   = cnt_acc_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    if (adv_i) begin
      if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
      if (valid_i) begin
        if (last_i) begin
          p_d         = result;
          ovf_d       = grp_ovf;
          cnt_d       = cnt_inc;
          out_valid_d = 1'b1;
          acc_d       = '0;
          ovf_acc_d   = 1'b0;
          cnt_acc_d   = '0;
          state_d     = IDLE;
        end else begin
          acc_d       = result;
          ovf_acc_d   = grp_ovf;
          cnt_acc_d   = cnt_inc;
          state_d     = ACCUM;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      cnt_acc_q   <= '0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      cnt_acc_q   <= cnt_acc_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign p_o         = p_q;
  assign ovf_o       = ovf_q;
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - streaming pre-add/multiply/accumulate pipeline with backpressure
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 48,
  parameter int CNT_WIDTH = 8,
  parameter int SATURATE  = 1
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic signed [A_WIDTH-1:0]  A,
  input  logic signed [B_WIDTH-1:0]  B,
  input  logic signed [B_WIDTH-1:0]  D,
  input  logic signed [P_WIDTH-1:0]  C,
  input  logic [OP_WIDTH-1:0]        OP,
  input  logic                       LAST,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic signed [P_WIDTH-1:0]  P,
  output logic                       OVF,
  output logic [CNT_WIDTH-1:0]       CNT
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;

  if (P_WIDTH < A_WIDTH + B_WIDTH + 2) begin : g_width_check
    $error("dsp_mac_pipe: P_WIDTH must be at least A_WIDTH+B_WIDTH+2");
  end

  logic adv;

  // S1 registers
  logic                      s1_valid_q;
  logic signed [A_WIDTH-1:0] a_q;
  logic signed [B_WIDTH-1:0] b_q;
  logic signed [B_WIDTH-1:0] d_q;
  logic signed [P_WIDTH-1:0] c_q;
  logic [OP_WIDTH-1:0]       op_q;
  logic                      last_q;

  // S2 operand formation and registers
  logic signed [B_WIDTH:0]   b_ext;
  logic signed [B_WIDTH:0]   d_ext;
  logic signed [B_WIDTH:0]   pre;
  logic signed [B_WIDTH:0]   opnd;
  logic signed [M_WIDTH-1:0] a_m;
  logic signed [M_WIDTH-1:0] o_m;
  logic signed [M_WIDTH-1:0] m_d;

  logic                      s2_valid_q;
  logic signed [M_WIDTH-1:0] m_q;
  logic signed [P_WIDTH-1:0] c2_q;
  logic                      post_sub_q;
  logic                      load_c_q;
  logic                      last2_q;

  // The whole pipe advances together; a held result with no taker freezes everything.
  assign adv      = !OUT_VALID || OUT_READY;
  assign IN_READY = adv;

  // S1: capture the incoming beat; bubbles enter as valid=0.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
      c_q        <= '0;
      op_q       <= '0;
      last_q     <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= IN_VALID;
      a_q        <= A;
      b_q        <= B;
      d_q        <= D;
      c_q        <= C;
      op_q       <= OP;
      last_q     <= LAST;
    end
  end

  // Pre-adder in B_WIDTH+1 bits, then a full-width signed product (operands pre-extended).
  always_comb begin
    b_ext = {b_q[B_WIDTH-1], b_q};
    d_ext = {d_q[B_WIDTH-1], d_q};
    pre   = op_q[OP_PRE_SUB] ? (d_ext - b_ext) : (d_ext + b_ext);
    opnd  = op_q[OP_PRE_EN] ? pre : b_ext;
    a_m   = {{(M_WIDTH - A_WIDTH){a_q[A_WIDTH-1]}}, a_q};
    o_m   = {{(M_WIDTH - B_WIDTH - 1){opnd[B_WIDTH]}}, opnd};
    m_d   = a_m * o_m;
  end

  // S2: register the product with the controls the accumulator still needs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s2_valid_q <= 1'b0;
      m_q        <= '0;
      c2_q       <= '0;
      post_sub_q <= 1'b0;
      load_c_q   <= 1'b0;
      last2_q    <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      m_q        <= m_d;
      c2_q       <= c_q;
      post_sub_q <= op_q[OP_POST_SUB];
      load_c_q   <= op_q[OP_LOAD_C];
      last2_q    <= last_q;
    end
  end

  dsp_mac_acc #(
    .M_WIDTH   (M_WIDTH),
    .P_WIDTH   (P_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .SATURATE  (SATURATE)
  ) u_acc (
    .clk_i       (CLK),
    .rst_ni      (RSTN),
    .adv_i       (adv),
    .valid_i     (s2_valid_q),
    .m_i         (m_q),
    .c_i         (c2_q),
    .post_sub_i  (post_sub_q),
    .load_c_i    (load_c_q),
    .last_i      (last2_q),
    .out_ready_i (OUT_READY),
    .out_valid_o (OUT_VALID),
    .p_o         (P),
    .ovf_o       (OVF),
    .cnt_o       (CNT)
  );

endmodule
